// File: rtl/ym_bus_pkg.sv
// ym_bus_pkg: shared types for the YM2610 write sequencer.
//   ym_state_t - write sequencer FSM states
//   ADDR_PHASE / DATA_PHASE - low bit of ADDR_S for each strobe type
//   ym_cmd_t   - queued command word {part, reg_idx, data}
package ym_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_A_WAIT,
    ST_A_STB,
    ST_A_HOLD,
    ST_D_WAIT,
    ST_D_STB,
    ST_D_HOLD
  } ym_state_t;

  localparam logic ADDR_PHASE = 1'b0;
  localparam logic DATA_PHASE = 1'b1;

  localparam int CMD_W = 17;

  typedef struct packed {
    logic       part;
    logic [7:0] reg_idx;
    logic [7:0] data;
  } ym_cmd_t;

endpackage

// File: rtl/ym_cmd_fifo.sv
// ym_cmd_fifo: first-word fall-through command FIFO.
//   PHI_M  - clock, rising edge
//   nRESET - asynchronous active-low reset, empties the FIFO
//   push   - write din (ignored when full)
//   pop    - discard head (ignored when empty)
//   din    - word to write
//   dout   - head word, valid whenever !empty
//   full   - DEPTH words stored
//   empty  - no words stored
//   level  - occupancy, 0..DEPTH
module ym_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 17
) (
  input  logic                     PHI_M,
  input  logic                     nRESET,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == FULL_LVL);
  assign empty   = (count == '0);
  assign level   = count;
  assign dout    = mem[rd_ptr];

  // Storage has no reset so it can map onto plain RAM; stale contents are
  // never visible because empty gates every read.
  always_ff @(posedge PHI_M) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; the separate
  // occupancy counter disambiguates full from empty.
  always_ff @(posedge PHI_M or negedge nRESET) begin
    if (!nRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ym_write_seq.sv
// ym_write_seq: queues (part, register, value) commands and replays them as
// address/data write strobes on the YM2610 register port.
//   PHI_M     - clock, rising edge
//   nRESET    - asynchronous active-low reset
//   CMD_VALID / CMD_READY - command handshake, READY = !full
//   CMD_PART / CMD_REG / CMD_DATA - command fields
//   nWRITE_S  - one-cycle active-low write strobe
//   ADDR_S    - {part, phase}, phase 0 = address, 1 = data
//   DATA_S    - register index or value for the current strobe
//   BUSY_MMR  - YM port busy, sampled only while waiting to strobe
//   IDLE      - nothing queued and nothing in flight
//   LEVEL     - FIFO occupancy
module ym_write_seq
  import ym_bus_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter bit ADDR_CACHE = 1'b1
) (
  input  logic                     PHI_M,
  input  logic                     nRESET,
  input  logic                     CMD_VALID,
  output logic                     CMD_READY,
  input  logic                     CMD_PART,
  input  logic [7:0]               CMD_REG,
  input  logic [7:0]               CMD_DATA,
  output logic                     nWRITE_S,
  output logic [1:0]               ADDR_S,
  output logic [7:0]               DATA_S,
  input  logic                     BUSY_MMR,
  output logic                     IDLE,
  output logic [$clog2(DEPTH):0]   LEVEL
);

  ym_state_t  state;
  ym_cmd_t    work;
  ym_cmd_t    fifo_din;
  ym_cmd_t    fifo_dout;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic       cache_valid;
  logic       cache_part;
  logic [7:0] cache_reg;
  logic       cache_hit;

  assign CMD_READY = nRESET && !full;
  assign push      = CMD_VALID && CMD_READY;
  assign fifo_din  = {CMD_PART, CMD_REG, CMD_DATA};
  assign pop       = (state == ST_IDLE) && !empty;
  assign IDLE      = empty && (state == ST_IDLE);

  assign cache_hit = ADDR_CACHE && cache_valid &&
                     (cache_part == fifo_dout.part) &&
                     (cache_reg == fifo_dout.reg_idx);

  ym_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .PHI_M  (PHI_M),
    .nRESET (nRESET),
    .push   (push),
    .pop    (pop),
    .din    (fifo_din),
    .dout   (fifo_dout),
    .full   (full),
    .empty  (empty),
    .level  (LEVEL)
  );

  // Sequencer. The strobe and bus values are loaded on the edge that enters
  // a STB state, so nWRITE_S is low for exactly the STB cycle and the HOLD
  // state that always follows keeps strobes from ever touching. From IDLE
  // the head word is used directly because the working register is being
  // loaded on that same edge. A cache hit with the port free goes straight
  // to the data strobe, mirroring the address path skipping A_WAIT.
  always_ff @(posedge PHI_M or negedge nRESET) begin
    if (!nRESET) begin
      state       <= ST_IDLE;
      work        <= '0;
      cache_valid <= 1'b0;
      cache_part  <= 1'b0;
      cache_reg   <= '0;
      nWRITE_S    <= 1'b1;
      ADDR_S      <= '0;
      DATA_S      <= '0;
    end else begin
      nWRITE_S <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            work <= fifo_dout;
            if (cache_hit) begin
              if (BUSY_MMR) begin
                state <= ST_D_WAIT;
              end else begin
                state    <= ST_D_STB;
                nWRITE_S <= 1'b0;
                ADDR_S   <= {fifo_dout.part, DATA_PHASE};
                DATA_S   <= fifo_dout.data;
              end
            end else if (BUSY_MMR) begin
              state <= ST_A_WAIT;
            end else begin
              state       <= ST_A_STB;
              nWRITE_S    <= 1'b0;
              ADDR_S      <= {fifo_dout.part, ADDR_PHASE};
              DATA_S      <= fifo_dout.reg_idx;
              cache_valid <= 1'b1;
              cache_part  <= fifo_dout.part;
              cache_reg   <= fifo_dout.reg_idx;
            end
          end
        end
        ST_A_WAIT: begin
          if (!BUSY_MMR) begin
            state       <= ST_A_STB;
            nWRITE_S    <= 1'b0;
            ADDR_S      <= {work.part, ADDR_PHASE};
            DATA_S      <= work.reg_idx;
            cache_valid <= 1'b1;
            cache_part  <= work.part;
            cache_reg   <= work.reg_idx;
          end
        end
        ST_A_STB:  state <= ST_A_HOLD;
        ST_A_HOLD: state <= ST_D_WAIT;
        ST_D_WAIT: begin
          if (!BUSY_MMR) begin
            state    <= ST_D_STB;
            nWRITE_S <= 1'b0;
            ADDR_S   <= {work.part, DATA_PHASE};
            DATA_S   <= work.data;
          end
        end
        ST_D_STB:  state <= ST_D_HOLD;
        ST_D_HOLD: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ym_write_seq.sv
// tb_ym_write_seq: randomized and directed bench for ym_write_seq with a
// strobe scoreboard fed by a command-level reference model.
module tb_ym_write_seq;

  localparam int DEPTH = 8;

  logic       PHI_M = 1'b0;
  logic       nRESET = 1'b1;
  logic       CMD_VALID = 1'b0;
  logic       CMD_PART = 1'b0;
  logic [7:0] CMD_REG = '0;
  logic [7:0] CMD_DATA = '0;
  logic       CMD_READY;
  logic       nWRITE_S;
  logic [1:0] ADDR_S;
  logic [7:0] DATA_S;
  logic       BUSY_MMR;
  logic       IDLE;
  logic [3:0] LEVEL;

  logic ym_busy = 1'b0;
  logic force_busy = 1'b0;
  logic jitter = 1'b0;
  logic jitter_en = 1'b0;

  // Second instance with the address cache disabled.
  logic       nc_valid = 1'b0;
  logic       nc_part = 1'b0;
  logic [7:0] nc_reg = '0;
  logic [7:0] nc_data = '0;
  logic       nc_ready;
  logic       nc_nwr;
  logic [1:0] nc_addr;
  logic [7:0] nc_dout;
  logic       nc_busy = 1'b0;
  logic       nc_idle;
  logic [3:0] nc_level;
  int         nc_strobes = 0;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int nstrobes = 0;
  int last_cyc = -1;
  int gap_epoch = 0;
  int seen_epoch = -1;
  bit gap_on = 1'b0;
  int push_cyc = 0;
  logic [9:0] last_exp = '0;

  // Reference model state: expected strobes {ADDR_S, DATA_S} and the
  // last address written.
  logic [9:0] expq[$];
  bit         m_valid = 1'b0;
  logic       m_part = 1'b0;
  logic [7:0] m_reg = '0;

  logic [7:0] rset [3] = '{8'h10, 8'h11, 8'hA4};

  always #5 PHI_M = ~PHI_M;

  assign BUSY_MMR = ym_busy | force_busy | jitter;

  ym_write_seq #(.DEPTH(DEPTH), .ADDR_CACHE(1'b1)) dut (
    .PHI_M     (PHI_M),
    .nRESET    (nRESET),
    .CMD_VALID (CMD_VALID),
    .CMD_READY (CMD_READY),
    .CMD_PART  (CMD_PART),
    .CMD_REG   (CMD_REG),
    .CMD_DATA  (CMD_DATA),
    .nWRITE_S  (nWRITE_S),
    .ADDR_S    (ADDR_S),
    .DATA_S    (DATA_S),
    .BUSY_MMR  (BUSY_MMR),
    .IDLE      (IDLE),
    .LEVEL     (LEVEL)
  );

  ym_write_seq #(.DEPTH(DEPTH), .ADDR_CACHE(1'b0)) dut_nc (
    .PHI_M     (PHI_M),
    .nRESET    (nRESET),
    .CMD_VALID (nc_valid),
    .CMD_READY (nc_ready),
    .CMD_PART  (nc_part),
    .CMD_REG   (nc_reg),
    .CMD_DATA  (nc_data),
    .nWRITE_S  (nc_nwr),
    .ADDR_S    (nc_addr),
    .DATA_S    (nc_dout),
    .BUSY_MMR  (nc_busy),
    .IDLE      (nc_idle),
    .LEVEL     (nc_level)
  );

  // Register-file models: busy for the one cycle after each strobe.
  always @(posedge PHI_M) begin
    cyc++;
    ym_busy <= nRESET && !nWRITE_S;
    nc_busy <= nRESET && !nc_nwr;
  end

  always @(negedge PHI_M) begin
    jitter = jitter_en ? ($urandom_range(0, 3) == 0) : 1'b0;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic modelWrite(input logic p, input logic [7:0] r, input logic [7:0] d);
    if (!(m_valid && m_part == p && m_reg == r)) expq.push_back({p, 1'b0, r});
    expq.push_back({p, 1'b1, d});
    m_valid = 1'b1;
    m_part  = p;
    m_reg   = r;
  endtask

  // Offer one command for up to 'tries' cycles; READY is sampled mid-cycle
  // so an accepted offer is recorded in the model before its edge.
  task automatic applyStimulus(input logic p, input logic [7:0] r, input logic [7:0] d,
                               input int tries, output bit acc);
    acc = 1'b0;
    @(negedge PHI_M);
    CMD_VALID = 1'b1;
    CMD_PART  = p;
    CMD_REG   = r;
    CMD_DATA  = d;
    for (int i = 0; i < tries && !acc; i++) begin
      if (i > 0) @(negedge PHI_M);
      if (CMD_READY) begin
        modelWrite(p, r, d);
        acc = 1'b1;
      end
      @(posedge PHI_M);
    end
    #1;
    CMD_VALID = 1'b0;
    if (acc) push_cyc = cyc;
  endtask

  task automatic waitStrobe(input string name, output int c);
    c = -1;
    for (int i = 0; i < 200 && c < 0; i++) begin
      @(negedge PHI_M);
      if (nRESET && !nWRITE_S) c = cyc;
    end
    if (c < 0) checkOutput({name, "_timeout"}, 0, 1);
  endtask

  task automatic waitDrain(input string name);
    for (int i = 0; i < 3000 && expq.size() != 0; i++) @(posedge PHI_M);
    @(posedge PHI_M);
    checkOutput(name, expq.size(), 0);
  endtask

  // Monitor: every strobe must match the head of the expected queue and be
  // at least three cycles after the previous one (exactly three when a
  // back-to-back burst is being checked).
  always @(negedge PHI_M) begin
    if (nRESET && !nWRITE_S) begin
      nstrobes++;
      if (expq.size() == 0) begin
        checkOutput("unexpected_strobe", expq.size(), 1);
      end else begin
        last_exp = expq.pop_front();
        checkOutput("strobe", {22'd0, ADDR_S, DATA_S}, {22'd0, last_exp});
      end
      if (last_cyc >= 0) checkOutput("strobe_spacing", 32'(cyc - last_cyc >= 3), 1);
      if (gap_on) begin
        if (seen_epoch == gap_epoch) checkOutput("strobe_gap", cyc - last_cyc, 3);
        seen_epoch = gap_epoch;
      end
      last_cyc = cyc;
    end
  end

  always @(negedge PHI_M) begin
    if (nRESET && !nc_nwr) nc_strobes++;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit acc;
    int ca, cd, cs, rel, s0, acc_cnt;

    // Reset state.
    #3 nRESET = 1'b0;
    repeat (3) @(posedge PHI_M);
    #1;
    checkOutput("rst_nwrite", nWRITE_S, 1);
    checkOutput("rst_addr", ADDR_S, 0);
    checkOutput("rst_data", DATA_S, 0);
    checkOutput("rst_level", LEVEL, 0);
    checkOutput("rst_idle", IDLE, 1);
    checkOutput("rst_ready", CMD_READY, 0);
    @(negedge PHI_M);
    nRESET = 1'b1;
    @(posedge PHI_M);
    #1;
    checkOutput("ready_after_rst", CMD_READY, 1);

    // Single write A/0x27/0x15.
    applyStimulus(1'b0, 8'h27, 8'h15, 10, acc);
    waitStrobe("single_a", ca);
    checkOutput("push_to_strobe", ca - push_cyc, 1);
    checkOutput("single_a_bus", {ADDR_S, DATA_S}, {2'b00, 8'h27});
    waitStrobe("single_d", cd);
    checkOutput("addr_to_data", cd - ca, 3);
    checkOutput("single_d_bus", {ADDR_S, DATA_S}, {2'b01, 8'h15});
    repeat (2) @(posedge PHI_M);
    @(negedge PHI_M);
    checkOutput("idle_after_write", IDLE, 1);

    // Cache hit: second write to B/0x08 emits only a data strobe.
    s0 = nstrobes;
    applyStimulus(1'b1, 8'h08, 8'hDF, 50, acc);
    applyStimulus(1'b1, 8'h08, 8'hC0, 50, acc);
    waitDrain("cache_drain");
    checkOutput("cache_strobes", nstrobes - s0, 3);

    // Part switch with an equal register index needs a fresh address.
    s0 = nstrobes;
    applyStimulus(1'b0, 8'h10, 8'h80, 50, acc);
    applyStimulus(1'b1, 8'h10, 8'h01, 50, acc);
    waitDrain("part_drain");
    checkOutput("part_strobes", nstrobes - s0, 4);

    // Cache disabled: both writes emit address and data strobes.
    @(negedge PHI_M);
    nc_valid = 1'b1;
    nc_part  = 1'b1;
    nc_reg   = 8'h08;
    nc_data  = 8'hDF;
    @(posedge PHI_M);
    #1 nc_data = 8'hC0;
    @(posedge PHI_M);
    #1 nc_valid = 1'b0;
    repeat (30) @(posedge PHI_M);
    @(negedge PHI_M);
    checkOutput("nocache_strobes", nc_strobes, 4);
    checkOutput("nocache_last", {nc_addr, nc_dout}, {2'b11, 8'hC0});

    // BUSY stall before the data phase.
    applyStimulus(1'b1, 8'h44, 8'h99, 50, acc);
    waitStrobe("stall_a", ca);
    force_busy = 1'b1;
    @(posedge PHI_M);
    #1 s0 = nstrobes;
    repeat (20) @(posedge PHI_M);
    #1;
    force_busy = 1'b0;
    rel = cyc;
    checkOutput("stall_quiet", nstrobes, s0);
    waitStrobe("stall_d", cs);
    checkOutput("stall_release", cs - rel, 1);
    checkOutput("stall_d_bus", {ADDR_S, DATA_S}, {2'b11, 8'h99});
    waitDrain("stall_drain");

    // Fill with BUSY forced: one command is held in the working register,
    // DEPTH more fill the FIFO, the rest are refused.
    force_busy = 1'b1;
    acc_cnt = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), rset[$urandom_range(0, 2)],
                    8'($urandom_range(0, 255)), 2, acc);
      acc_cnt += int'(acc);
    end
    checkOutput("fill_accepted", acc_cnt, DEPTH + 1);
    checkOutput("fill_level", LEVEL, DEPTH);
    checkOutput("fill_ready", CMD_READY, 0);
    gap_epoch++;
    gap_on = 1'b1;
    force_busy = 1'b0;
    waitDrain("fill_drain");
    gap_on = 1'b0;

    // Reset during A_HOLD with three commands queued.
    force_busy = 1'b1;
    applyStimulus(1'b0, 8'h30, 8'h01, 10, acc);
    applyStimulus(1'b1, 8'h31, 8'h02, 10, acc);
    applyStimulus(1'b0, 8'h32, 8'h03, 10, acc);
    applyStimulus(1'b1, 8'h33, 8'h04, 10, acc);
    checkOutput("queued_level", LEVEL, 3);
    force_busy = 1'b0;
    waitStrobe("rst_a", ca);
    @(posedge PHI_M);
    #1;
    nRESET = 1'b0;
    expq.delete();
    m_valid = 1'b0;
    #1;
    checkOutput("midrst_nwrite", nWRITE_S, 1);
    checkOutput("midrst_level", LEVEL, 0);
    repeat (3) @(posedge PHI_M);
    @(negedge PHI_M);
    nRESET = 1'b1;
    s0 = nstrobes;
    repeat (20) @(posedge PHI_M);
    #1;
    checkOutput("post_rst_quiet", nstrobes, s0);
    checkOutput("post_rst_idle", IDLE, 1);
    applyStimulus(1'b0, 8'h30, 8'h5A, 10, acc);
    waitStrobe("post_rst_a", ca);
    checkOutput("post_rst_addr_phase", {ADDR_S, DATA_S}, {2'b00, 8'h30});
    waitDrain("post_rst_drain");

    // Randomized traffic with busy jitter and idle gaps.
    jitter_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge PHI_M);
      applyStimulus(1'($urandom_range(0, 1)), rset[$urandom_range(0, 2)],
                    8'($urandom_range(0, 255)), 200, acc);
      checkOutput("rand_accept", acc, 1);
    end
    waitDrain("rand_drain");
    jitter_en = 1'b0;
    repeat (8) @(posedge PHI_M);
    @(negedge PHI_M);
    checkOutput("final_idle", IDLE, 1);
    checkOutput("final_level", LEVEL, 0);
    checkOutput("bus_hold", {ADDR_S, DATA_S}, last_exp);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
